// File: rtl/np_boot_loader.sv
// Boot loader for the np core: receives a length-prefixed, XOR-checksummed byte image,
// writes big-endian 32-bit words to instruction memory and gates the core's reset.
module np_boot_loader #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int MEMSIZE  = 1 << ADDRSIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic                mem_wr,
    output logic [ADDRSIZE-1:0] mem_address,
    output logic [WIDTH-1:0]    mem_dataOut,
    output logic                cpu_reset,
    input  logic                halt,
    output logic                loaded,
    output logic                err,
    output logic [ADDRSIZE:0]   word_count
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t                state_reg, state_next;
    logic [15:0]           len_reg;
    logic [1:0]            byte_cnt_reg;
    logic [WIDTH-9:0]      shift_reg;
    logic [7:0]            csum_reg;
    logic [ADDRSIZE:0]     word_count_reg;

    logic                  rx_ready_reg;
    logic                  mem_wr_reg;
    logic [ADDRSIZE-1:0]   mem_address_reg;
    logic [WIDTH-1:0]      mem_dataOut_reg;
    logic                  cpu_reset_reg;
    logic                  loaded_reg;
    logic                  err_reg;

    logic                  accept;
    logic [15:0]           len_value;
    logic                  last_word;
    logic                  receiving_next;

    assign accept    = rx_valid && rx_ready_reg;
    assign len_value = {len_reg[15:8], rx_data};
    assign last_word = (16'(word_count_reg) + 16'd1) == len_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_LEN_HI;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LEN_HI: begin
                if (accept) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_value == 16'd0)
                        state_next = S_CSUM;
                    else if (32'(len_value) > MEMSIZE)
                        state_next = S_ERROR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byte_cnt_reg == 2'd3 && last_word) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (accept) state_next = (rx_data == csum_reg) ? S_RUN : S_ERROR;
            end
            S_RUN: begin
                if (halt) state_next = S_HALTED;
            end
            S_HALTED: state_next = S_LEN_HI;
            S_ERROR:  state_next = S_ERROR;
            default:  state_next = S_ERROR;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state itself.
    assign receiving_next = (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                            (state_next == S_DATA)   || (state_next == S_CSUM);

    always_ff @(posedge clk) begin
        if (reset) begin
            len_reg         <= '0;
            byte_cnt_reg    <= '0;
            shift_reg       <= '0;
            csum_reg        <= '0;
            word_count_reg  <= '0;
            rx_ready_reg    <= 1'b0;
            mem_wr_reg      <= 1'b0;
            mem_address_reg <= '0;
            mem_dataOut_reg <= '0;
            cpu_reset_reg   <= 1'b1;
            loaded_reg      <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            rx_ready_reg  <= receiving_next;
            cpu_reset_reg <= (state_next != S_RUN);
            loaded_reg    <= (state_next == S_RUN);
            err_reg       <= (state_next == S_ERROR);
            mem_wr_reg    <= 1'b0;

            // The checksum byte itself is excluded from the running XOR.
            if (accept && (state_reg == S_LEN_HI || state_reg == S_LEN_LO || state_reg == S_DATA))
                csum_reg <= csum_reg ^ rx_data;

            case (state_reg)
                S_LEN_HI: begin
                    if (accept) len_reg[15:8] <= rx_data;
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_reg[7:0] <= rx_data;
                        byte_cnt_reg <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            mem_wr_reg      <= 1'b1;
                            mem_dataOut_reg <= {shift_reg, rx_data};
                            mem_address_reg <= word_count_reg[ADDRSIZE-1:0];
                            word_count_reg  <= word_count_reg + 1'b1;
                        end else begin
                            shift_reg <= {shift_reg[WIDTH-17:0], rx_data};
                        end
                    end
                end
                S_HALTED: begin
                    len_reg        <= '0;
                    byte_cnt_reg   <= '0;
                    csum_reg       <= '0;
                    word_count_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign rx_ready    = rx_ready_reg;
    assign mem_wr      = mem_wr_reg;
    assign mem_address = mem_address_reg;
    assign mem_dataOut = mem_dataOut_reg;
    assign cpu_reset   = cpu_reset_reg;
    assign loaded      = loaded_reg;
    assign err         = err_reg;
    assign word_count  = word_count_reg;

endmodule

// File: tb/tb_np_boot_loader.sv
// Bench for np_boot_loader: frames are built here, expected memory writes are queued
// when a frame is sent and matched against the write strobes as they appear.
module tb_np_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        mem_wr;
    logic [11:0] mem_address;
    logic [31:0] mem_dataOut;
    logic        cpu_reset;
    logic        halt = 1'b0;
    logic        loaded;
    logic        err;
    logic [12:0] word_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    np_boot_loader dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_wr(mem_wr), .mem_address(mem_address), .mem_dataOut(mem_dataOut),
        .cpu_reset(cpu_reset), .halt(halt), .loaded(loaded), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (mem_wr !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h required=no write", mem_address, mem_dataOut);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_address !== mon_e.a || mem_dataOut !== mon_e.d) begin
                    failures++;
                    $display("FAIL mem_write got addr=%h data=%h required addr=%h data=%h",
                             mem_address, mem_dataOut, mon_e.a, mon_e.d);
                end else begin
                    $display("write addr=%h data=%h ok", mem_address, mem_dataOut);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic build_frame(input logic [31:0] w[$], output logic [7:0] fr[$]);
        logic [7:0]  cs;
        logic [15:0] n;
        fr = {};
        n = 16'(w.size());
        fr.push_back(n[15:8]);
        fr.push_back(n[7:0]);
        foreach (w[i]) for (int k = 3; k >= 0; k--) fr.push_back(w[i][8*k +: 8]);
        cs = 8'h00;
        foreach (fr[i]) cs ^= fr[i];
        fr.push_back(cs);
    endtask

    task automatic push_writes(input logic [31:0] w[$]);
        wr_t e;
        foreach (w[i]) begin
            e.a = 12'(i);
            e.d = w[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
                if (rx_ready === 1'b1) begin
                    @(posedge clk);
                    ok = 1'b1;
                end
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL byte_accept_timeout byte=%h rx_ready=%b required=accepted within 100 cycles", b, rx_ready);
        end
    endtask

    // Sends the first cnt bytes, then stops driving at the following negedge.
    task automatic send_bytes(input logic [7:0] fr[$], input bit gaps, input int cnt);
        for (int i = 0; i < cnt && i < fr.size(); i++) send_byte(fr[i], gaps);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; rx_valid = 1'b0; halt = 1'b0;
        @(negedge clk);
        checks += 8;
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL rst_rx_ready got=%b required=0", rx_ready); end
        if (mem_wr !== 1'b0) begin failures++; $display("FAIL rst_mem_wr got=%b required=0", mem_wr); end
        if (mem_address !== 12'h0) begin failures++; $display("FAIL rst_mem_address got=%h required=0", mem_address); end
        if (mem_dataOut !== 32'h0) begin failures++; $display("FAIL rst_mem_dataOut got=%h required=0", mem_dataOut); end
        if (cpu_reset !== 1'b1) begin failures++; $display("FAIL rst_cpu_reset got=%b required=1", cpu_reset); end
        if (loaded !== 1'b0) begin failures++; $display("FAIL rst_loaded got=%b required=0", loaded); end
        if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b required=0", err); end
        if (word_count !== 13'd0) begin failures++; $display("FAIL rst_word_count got=%0d required=0", word_count); end
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin failures++; $display("FAIL rst_release_rx_ready got=%b required=1", rx_ready); end
        $display("reset applied");
    endtask

    task automatic test_reset();
        apply_reset();
        // halt outside RUN must not disturb the idle loader
        @(negedge clk); halt = 1'b1;
        @(negedge clk); halt = 1'b0;
        @(negedge clk);
        checks += 3;
        if (rx_ready !== 1'b1) begin failures++; $display("FAIL idle_halt_rx_ready got=%b required=1", rx_ready); end
        if (cpu_reset !== 1'b1) begin failures++; $display("FAIL idle_halt_cpu_reset got=%b required=1", cpu_reset); end
        if (loaded !== 1'b0) begin failures++; $display("FAIL idle_halt_loaded got=%b required=0", loaded); end
        $display("test_reset done");
    endtask

    task automatic test_load(input bit gaps);
        logic [31:0] w[$];
        logic [7:0]  fr[$];
        w = {32'h30001000, 32'hB0000000};
        build_frame(w, fr);
        push_writes(w);
        send_bytes(fr, gaps, fr.size());
        checks += 6;
        if (cpu_reset !== 1'b0) begin failures++; $display("FAIL load_cpu_reset got=%b required=0", cpu_reset); end
        if (loaded !== 1'b1) begin failures++; $display("FAIL load_loaded got=%b required=1", loaded); end
        if (word_count !== 13'd2) begin failures++; $display("FAIL load_word_count got=%0d required=2", word_count); end
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL load_rx_ready got=%b required=0", rx_ready); end
        if (err !== 1'b0) begin failures++; $display("FAIL load_err got=%b required=0", err); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL load_writes_pending got=%0d required=0", exp_q.size()); end
        $display("test_load gaps=%0d done", gaps);
    endtask

    task automatic test_bad_csum();
        logic [31:0] w[$];
        logic [7:0]  fr[$];
        apply_reset();
        w = {32'h30001000, 32'hB0000000};
        build_frame(w, fr);
        fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
        push_writes(w);
        send_bytes(fr, 1'b0, fr.size());
        repeat (3) @(negedge clk);
        checks += 5;
        if (err !== 1'b1) begin failures++; $display("FAIL badcs_err got=%b required=1", err); end
        if (cpu_reset !== 1'b1) begin failures++; $display("FAIL badcs_cpu_reset got=%b required=1", cpu_reset); end
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL badcs_rx_ready got=%b required=0", rx_ready); end
        if (loaded !== 1'b0) begin failures++; $display("FAIL badcs_loaded got=%b required=0", loaded); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL badcs_writes_pending got=%0d required=0", exp_q.size()); end
        $display("test_bad_csum done");
    endtask

    task automatic test_too_long();
        logic [7:0] fr[$];
        apply_reset();
        fr = {8'h10, 8'h01};
        send_bytes(fr, 1'b0, 2);
        checks += 2;
        if (err !== 1'b1) begin failures++; $display("FAIL toolong_err got=%b required=1", err); end
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL toolong_rx_ready got=%b required=0", rx_ready); end
        // bytes offered in ERROR are ignored; any write would hit the empty scoreboard
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'(8'hA0 + i);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        checks += 2;
        if (err !== 1'b1) begin failures++; $display("FAIL toolong_err_sticky got=%b required=1", err); end
        if (cpu_reset !== 1'b1) begin failures++; $display("FAIL toolong_cpu_reset got=%b required=1", cpu_reset); end
        $display("test_too_long done");
    endtask

    task automatic test_empty();
        logic [31:0] w[$];
        logic [7:0]  fr[$];
        apply_reset();
        w = {};
        build_frame(w, fr);
        send_bytes(fr, 1'b0, fr.size());
        checks += 3;
        if (loaded !== 1'b1) begin failures++; $display("FAIL empty_loaded got=%b required=1", loaded); end
        if (cpu_reset !== 1'b0) begin failures++; $display("FAIL empty_cpu_reset got=%b required=0", cpu_reset); end
        if (word_count !== 13'd0) begin failures++; $display("FAIL empty_word_count got=%0d required=0", word_count); end
        $display("test_empty done");
    endtask

    task automatic test_halt_reload();
        logic [31:0] w[$];
        logic [7:0]  fr[$];
        apply_reset();
        test_load(1'b0);
        @(negedge clk); halt = 1'b1;
        @(negedge clk); halt = 1'b0;
        checks += 2;
        if (cpu_reset !== 1'b1) begin failures++; $display("FAIL halt_cpu_reset got=%b required=1", cpu_reset); end
        if (loaded !== 1'b0) begin failures++; $display("FAIL halt_loaded got=%b required=0", loaded); end
        @(negedge clk);
        checks += 3;
        if (rx_ready !== 1'b1) begin failures++; $display("FAIL rearm_rx_ready got=%b required=1", rx_ready); end
        if (word_count !== 13'd0) begin failures++; $display("FAIL rearm_word_count got=%0d required=0", word_count); end
        if (cpu_reset !== 1'b1) begin failures++; $display("FAIL rearm_cpu_reset got=%b required=1", cpu_reset); end
        w = {32'h11223344};
        build_frame(w, fr);
        push_writes(w);
        send_bytes(fr, 1'b0, fr.size());
        checks += 4;
        if (loaded !== 1'b1) begin failures++; $display("FAIL reload_loaded got=%b required=1", loaded); end
        if (cpu_reset !== 1'b0) begin failures++; $display("FAIL reload_cpu_reset got=%b required=0", cpu_reset); end
        if (word_count !== 13'd1) begin failures++; $display("FAIL reload_word_count got=%0d required=1", word_count); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL reload_writes_pending got=%0d required=0", exp_q.size()); end
        $display("test_halt_reload done");
    endtask

    task automatic test_reset_mid_image();
        logic [31:0] w[$];
        logic [7:0]  fr[$];
        apply_reset();
        w = {32'h30001000, 32'hB0000000};
        build_frame(w, fr);
        push_writes(w);
        send_bytes(fr, 1'b1, 5);
        apply_reset();
        test_load(1'b1);
        $display("test_reset_mid_image done");
    endtask

    initial begin
        test_reset();
        test_load(1'b0);
        test_bad_csum();
        test_too_long();
        test_empty();
        test_halt_reload();
        test_reset_mid_image();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
